rca_pipe: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 4-bit RCA.
- Operand width is split into equal segments. Each pipeline stage ripples one segment and registers its carry into the next stage.
- Valid/ready handshake on input and output with full backpressure.
- Used wherever datapath sums wider than one cycle's ripple budget are needed.

---
 rtl/rca_pipe.sv | 146 ++++++++++++++
 tb/tb_rca_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor. Each stage ripples SEG_W bits and registers its carry.
// Optional macro RCA_PIPE_OVF_EN adds the registered signed-overflow output ovf.
module rca_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned NSEG = WIDTH / SEG_W;

    if (WIDTH % SEG_W != 0) begin : g_bad_param
        $error("rca_pipe: WIDTH (%0d) must be an integer multiple of SEG_W (%0d)", WIDTH, SEG_W);
    end

    logic [NSEG-1:0]  valid_q;
    logic [NSEG-1:0]  carry_q;
    logic [WIDTH-1:0] sum_q [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];

    logic [NSEG-1:0]  adv;
    logic [NSEG-1:0]  valid_nx;
    logic [NSEG-1:0]  carry_nx;
    logic [WIDTH-1:0] sum_nx [NSEG];
    logic [WIDTH-1:0] a_nx   [NSEG];
    logic [WIDTH-1:0] b_nx   [NSEG];

`ifdef RCA_PIPE_OVF_EN
    logic [NSEG-1:0]  ovf_q;
    logic [NSEG-1:0]  ovf_nx;
`endif

    // Advance chain runs from the output back to the input; in_ready never depends on in_valid.
    always_comb begin
        adv = '0;
        adv[NSEG-1] = !valid_q[NSEG-1] || out_ready;
        for (int unsigned k = NSEG - 1; k > 0; k--) begin
            adv[k-1] = !valid_q[k-1] || adv[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[NSEG-1];
    assign sum       = sum_q[NSEG-1];
    assign cout      = carry_q[NSEG-1];
`ifdef RCA_PIPE_OVF_EN
    assign ovf       = ovf_q[NSEG-1];
`endif

    always_comb begin
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic             c;
        logic             c_msb;
        ai       = '0;
        bi       = '0;
        si       = '0;
        c        = 1'b0;
        c_msb    = 1'b0;
        valid_nx = '0;
        carry_nx = '0;
        sum_nx   = '{default: '0};
        a_nx     = '{default: '0};
        b_nx     = '{default: '0};
`ifdef RCA_PIPE_OVF_EN
        ovf_nx   = '0;
`endif
        for (int unsigned k = 0; k < NSEG; k++) begin
            if (k == 0) begin
                valid_nx[k] = in_valid;
                ai          = a;
                bi          = b ^ {WIDTH{sub}};
                si          = '0;
                c           = cin ^ sub;
            end else begin
                valid_nx[k] = valid_q[k-1];
                ai          = a_q[k-1];
                bi          = b_q[k-1];
                si          = sum_q[k-1];
                c           = carry_q[k-1];
            end
            c_msb = c;
            for (int unsigned i = 0; i < SEG_W; i++) begin
                c_msb                = c;
                si[k*SEG_W + i]      = ai[k*SEG_W + i] ^ bi[k*SEG_W + i] ^ c;
                c                    = (ai[k*SEG_W + i] & bi[k*SEG_W + i]) |
                                       (c & (ai[k*SEG_W + i] ^ bi[k*SEG_W + i]));
            end
            sum_nx[k]   = si;
            a_nx[k]     = ai;
            b_nx[k]     = bi;
            carry_nx[k] = c;
`ifdef RCA_PIPE_OVF_EN
            ovf_nx[k]   = c ^ c_msb;
`endif
        end
    end

    // Data only loads alongside a valid transaction so outputs hold their last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int unsigned k = 0; k < NSEG; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
`ifdef RCA_PIPE_OVF_EN
            ovf_q   <= '0;
`endif
        end else begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_nx[k];
                    if (valid_nx[k]) begin
                        sum_q[k]   <= sum_nx[k];
                        a_q[k]     <= a_nx[k];
                        b_q[k]     <= b_nx[k];
                        carry_q[k] <= carry_nx[k];
`ifdef RCA_PIPE_OVF_EN
                        ovf_q[k]   <= ovf_nx[k];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: scoreboard bench for rca_pipe; expected results come from plain integer arithmetic.
// Checks ovf as well when RCA_PIPE_OVF_EN is defined.
module tb_rca_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned SEG_W = 4;
    localparam int unsigned NSEG  = WIDTH / SEG_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RCA_PIPE_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef RCA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               issue;
        bit               chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc   = 0;
    bit   rnd_on;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [WIDTH-1:0] aa, logic [WIDTH-1:0] bb, logic ci, logic s);
        exp_t m;
        int   ua, ub, r, sa, sbv, sr;
        ua  = int'(aa);
        ub  = int'(bb);
        sa  = $signed(aa);
        sbv = $signed(bb);
        if (!s) begin
            r  = ua + ub + int'(ci);
            sr = sa + sbv + int'(ci);
            m.cout = (r >= (1 << WIDTH));
        end else begin
            r  = ua - ub - int'(ci);
            sr = sa - sbv - int'(ci);
            m.cout = (r >= 0);
        end
        m.sum     = r[WIDTH-1:0];
        m.ovf     = (sr > ((1 << (WIDTH - 1)) - 1)) || (sr < -(1 << (WIDTH - 1)));
        m.issue   = 0;
        m.chk_lat = 1'b0;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every output transfer, checks hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got sum=%0h cout=%0b, expected no output", sum, cout);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef RCA_PIPE_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                if (e.chk_lat) check("latency", cyc - e.issue, NSEG);
            end
        end else if (rst_n && out_valid && !out_ready && sb.size() > 0) begin
            check("stall_sum", 32'(sum), 32'(sb[0].sum));
            check("stall_cout", 32'(cout), 32'(sb[0].cout));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic ci, input logic s, input bit lat);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1;
        a = aa; b = bb; cin = ci; sub = s;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e = model(aa, bb, ci, s);
                e.issue = cyc;
                e.chk_lat = lat;
                sb.push_back(e);
                n_acc++;
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int base;
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed, back-to-back, out_ready held high, latency checked
        send(8'h65, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(3);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        send(8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
        send(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        send(8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
        send(8'h05, 8'h05, 1'b1, 1'b1, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        send(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: four offered while out_ready is low for six cycles
        base = n_acc;
        fork
            begin
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                check("stall_accepted", n_acc - base, 2);
                check("stall_in_ready", 32'(in_ready), 0);
                out_ready = 1'b1;
            end
            begin
                send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
                send(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
                send(8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
                send(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
            end
        join
        drain();

        // Reset with two transactions in flight
        send(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        send(8'h56, 8'h78, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_sum", 32'(sum), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_quiet", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(8'h21, 8'h43, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomised traffic with random backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
